// File: rtl/serial_alu_arbiter.sv
// serial_alu_arbiter: two requesters share one bit-serial ALU.
// A round-robin arbiter picks an owner, the owner's operands are latched,
// the ALU processes one bit per cycle LSB first, and the finished result is
// published on the EXEC->DONE edge together with a one-cycle done pulse.
// Optional macro SERIAL_ALU_FLAGS_EN adds the zero and ovf result flags.
//
// Handshake: req[i] is a level request. gnt[i] is high from LOAD through DONE
// of the operation owned by requester i. done[i] pulses for one cycle in DONE.
// Operands are sampled only at the end of the LOAD cycle. A request seen in IDLE
// is always carried to completion, even if req drops afterwards. A new request
// is taken only from IDLE, which is the cycle after DONE.
module serial_alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
`ifdef SERIAL_ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q;     // requester that owns the current operation
  logic             last_q;      // requester granted most recently
  logic             winner;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [2:0]       op_q;

  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;
  logic             is_arith;
  logic             bit_a, bit_b, bit_p, sum_bit, carry_gen, res_bit;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero_q, ovf_q;
`endif

  // Reserved opcodes 101-111 fold onto ADD so the datapath sees five ops only.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    logic [2:0] n;
    case (op)
      OP_SUB:  n = OP_SUB;
      OP_XOR:  n = OP_XOR;
      OP_AND:  n = OP_AND;
      OP_OR:   n = OP_OR;
      default: n = OP_ADD;
    endcase
    return n;
  endfunction

  // Round-robin choice: on a tie the requester not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_q;
    else              winner = req[1];
  end

  // Operand mux feeding the LOAD-cycle latch.
  always_comb begin
    sel_a  = owner_q ? a1 : a0;
    sel_b  = owner_q ? b1 : b0;
    sel_op = norm_op(owner_q ? op1 : op0);
  end

  // One-bit ALU slice plus the result shift-register input.
  always_comb begin
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    bit_a     = a_sh[0];
    bit_b     = b_sh[0];
    bit_p     = bit_a ^ bit_b;
    sum_bit   = bit_p ^ carry_q;
    carry_gen = (bit_a & bit_b) | (bit_p & carry_q);
    case (op_q)
      OP_XOR:  res_bit = bit_p;
      OP_AND:  res_bit = bit_a & bit_b;
      OP_OR:   res_bit = bit_a | bit_b;
      default: res_bit = sum_bit;
    endcase
    r_next   = (r_sh >> 1) | {res_bit, {(WIDTH-1){1'b0}}};
    last_bit = (cnt_q == CNT_LAST);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    done    = 2'b00;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) state_d = LOAD;
      end
      LOAD: begin
        gnt     = owner_q ? 2'b10 : 2'b01;
        state_d = EXEC;
      end
      EXEC: begin
        gnt = owner_q ? 2'b10 : 2'b01;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        gnt     = owner_q ? 2'b10 : 2'b01;
        done    = owner_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, owner capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req != 2'b00) owner_q <= winner;
      if (state_q == LOAD) last_q <= owner_q;
    end
  end

  // Serial datapath: latch in LOAD, one bit per EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
    end else if (state_q == LOAD) begin
      a_sh    <= sel_a;
      b_sh    <= (sel_op == OP_SUB) ? ~sel_b : sel_b;
      cnt_q   <= '0;
      carry_q <= (sel_op == OP_SUB);
      op_q    <= sel_op;
    end else if (state_q == EXEC) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_next;
      cnt_q <= cnt_q + CW'(1);
      if (is_arith) carry_q <= carry_gen;
    end
  end

  // Published result: changes only when the last bit completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (state_q == EXEC && last_bit) begin
      result_q <= r_next;
      cout_q   <= is_arith & carry_gen;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q   <= (r_next == '0);
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf_q    <= is_arith & (carry_q ^ carry_gen);
`endif
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_alu_arbiter.sv
// Testbench for serial_alu_arbiter (WIDTH=8): directed scenarios with literal
// expectations plus randomized traffic checked cycle by cycle against a
// transaction-level model of the arbiter and ALU.
module tb_serial_alu_arbiter;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic [1:0]   gnt, done, dbg_state;
  logic         busy, carry_out;
  logic [W-1:0] result;
  logic         zero_w, ovf_w;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero, ovf;
  assign zero_w = zero;
  assign ovf_w  = ovf;
`else
  assign zero_w = 1'b0;
  assign ovf_w  = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt(gnt), .busy(busy), .done(done), .result(result), .carry_out(carry_out),
`ifdef SERIAL_ALU_FLAGS_EN
    .zero(zero), .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for one whole operation.
  task automatic alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         output logic [W-1:0] res, output logic c, output logic v);
    logic [W:0] s;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_SUB: begin
        s   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        res = s[W-1:0];
        c   = s[W];
        v   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_XOR: res = a ^ b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      default: begin
        s   = {1'b0, a} + {1'b0, b};
        res = s[W-1:0];
        c   = s[W];
        v   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
    endcase
  endtask

  // Transaction model: an accepted request occupies W+3 cycles
  // (LOAD, W EXEC cycles, DONE, then IDLE before another may start).
  bit           m_init = 0;
  bit           m_active = 0;
  int           m_t = 0;
  int           m_owner = 0;
  int           m_ptr = 1;
  logic [W-1:0] m_a, m_b, m_res;
  logic [2:0]   m_op;
  logic         m_cout, m_zero, m_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_active = 0; m_t = 0; m_ptr = 1;
      m_res = '0; m_cout = 0; m_zero = 0; m_ovf = 0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        m_active = 1;
        m_t = 0;
        m_owner = (req == 2'b11) ? (1 - m_ptr) : (req[1] ? 1 : 0);
      end
    end else begin
      m_t++;
      if (m_t == 1) begin
        m_ptr = m_owner;
        m_a  = (m_owner == 1) ? a1 : a0;
        m_b  = (m_owner == 1) ? b1 : b0;
        m_op = (m_owner == 1) ? op1 : op0;
      end
      if (m_t == W + 1) begin
        alu_ref(m_a, m_b, m_op, m_res, m_cout, m_ovf);
        m_zero = (m_res == '0);
      end
      if (m_t == W + 2) m_active = 0;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    logic [1:0] e_gnt, e_done;
    if (m_init) begin
      e_gnt  = m_active ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_done = (m_active && m_t == W + 1) ? e_gnt : 2'b00;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      chk("result", 32'(result), 32'(m_res));
      chk("carry_out", 32'(carry_out), 32'(m_cout));
`ifdef SERIAL_ALU_FLAGS_EN
      chk("zero", 32'(zero), 32'(m_zero));
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its done pulse.
  task automatic run_op(input logic [1:0] r,
                        input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic [2:0] xo0,
                        input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic [2:0] xo1,
                        input bit drop, input bit disturb,
                        output logic [1:0] g, output logic [1:0] d, output logic [W-1:0] res,
                        output logic c, output logic z, output logic v, output int lat);
    bit seen;
    req = r; a0 = xa0; b0 = xb0; op0 = xo0; a1 = xa1; b1 = xb1; op1 = xo1;
    tick();
    lat = 1;
    g = gnt;
    if (drop) req = 2'b00;
    seen = 0;
    d = 2'b00; res = '0; c = 0; z = 0; v = 0;
    for (int i = 0; i < 4 * W + 10 && !seen; i++) begin
      tick();
      lat++;
      if (disturb && lat == 5) begin
        a0 = W'($urandom); b0 = W'($urandom); op0 = 3'($urandom);
        a1 = W'($urandom); b1 = W'($urandom); op1 = 3'($urandom);
      end
      if (done != 2'b00) begin
        seen = 1;
        d = done; res = result; c = carry_out; z = zero_w; v = ovf_w;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", 4 * W + 10);
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    logic [1:0]   g, d;
    logic [W-1:0] res;
    logic         c, z, v;
    int           lat;
    logic [1:0]   seq_d[4];
    logic [W-1:0] seq_r[4];
    int           nd;

    rst = 1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = OP_ADD; op1 = OP_ADD;
    tick(); tick();
    rst = 0;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_gnt", 32'(gnt), 32'(0));
    chk("reset_result", 32'(result), 32'(0));
    chk("reset_state", 32'(dbg_state), 32'(0));

    // ADD on requester 0, latency and overflow
    run_op(2'b01, 8'h5A, 8'h3C, OP_ADD, 8'h00, 8'h00, OP_ADD, 1, 0, g, d, res, c, z, v, lat);
    chk("add_gnt", 32'(g), 32'(2'b01));
    chk("add_latency", 32'(lat), 32'(W + 2));
    chk("add_done", 32'(d), 32'(2'b01));
    chk("add_result", 32'(res), 32'(8'h96));
    chk("add_carry", 32'(c), 32'(0));
`ifdef SERIAL_ALU_FLAGS_EN
    chk("add_zero", 32'(z), 32'(0));
    chk("add_ovf", 32'(v), 32'(1));
`endif

    // SUB on requester 1, with and without borrow; req held through the op
    run_op(2'b10, 8'h00, 8'h00, OP_ADD, 8'h10, 8'h01, OP_SUB, 0, 0, g, d, res, c, z, v, lat);
    chk("sub_gnt", 32'(g), 32'(2'b10));
    chk("sub_done", 32'(d), 32'(2'b10));
    chk("sub_result", 32'(res), 32'(8'h0F));
    chk("sub_carry", 32'(c), 32'(1));
    run_op(2'b10, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h01, OP_SUB, 1, 0, g, d, res, c, z, v, lat);
    chk("sub_borrow_result", 32'(res), 32'(8'hFF));
    chk("sub_borrow_carry", 32'(c), 32'(0));

    // Reset in the 4th EXEC cycle abandons the operation
    req = 2'b01; a0 = 8'h12; b0 = 8'h34; op0 = OP_ADD;
    tick();
    req = 2'b00;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_gnt", 32'(gnt), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    run_op(2'b11, 8'hF0, 8'h0F, OP_XOR, 8'hF0, 8'h0F, OP_XOR, 1, 0, g, d, res, c, z, v, lat);
    chk("after_abort_gnt", 32'(g), 32'(2'b01));

    // Operand changes during EXEC are ignored
    run_op(2'b01, 8'hFF, 8'h01, OP_ADD, 8'h00, 8'h00, OP_ADD, 1, 1, g, d, res, c, z, v, lat);
    chk("hold_result", 32'(res), 32'(8'h00));
    chk("hold_carry", 32'(c), 32'(1));
`ifdef SERIAL_ALU_FLAGS_EN
    chk("hold_zero", 32'(z), 32'(1));
`endif

    // AND with req dropped after LOAD; reserved opcode acts as ADD
    run_op(2'b01, 8'hCC, 8'hAA, OP_AND, 8'h00, 8'h00, OP_ADD, 1, 0, g, d, res, c, z, v, lat);
    chk("and_done", 32'(d), 32'(2'b01));
    chk("and_result", 32'(res), 32'(8'h88));
    chk("and_carry", 32'(c), 32'(0));
    run_op(2'b01, 8'hF0, 8'h20, 3'b111, 8'h00, 8'h00, OP_ADD, 1, 0, g, d, res, c, z, v, lat);
    chk("op7_result", 32'(res), 32'(8'h10));
    chk("op7_carry", 32'(c), 32'(1));

    // Continuous tie after reset alternates grants
    rst = 1;
    tick();
    rst = 0;
    req = 2'b11; a0 = 8'hF0; b0 = 8'h0F; op0 = OP_XOR; a1 = 8'hF0; b1 = 8'h0F; op1 = OP_XOR;
    nd = 0;
    for (int i = 0; i < 8 * (W + 3) && nd < 4; i++) begin
      tick();
      if (done != 2'b00) begin
        seq_d[nd] = done;
        seq_r[nd] = result;
        nd++;
      end
    end
    req = 2'b00;
    chk("tie_count", 32'(nd), 32'(4));
    for (int i = 0; i < nd; i++) begin
      chk($sformatf("tie_done%0d", i), 32'(seq_d[i]), 32'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk($sformatf("tie_result%0d", i), 32'(seq_r[i]), 32'(8'hFF));
    end
    repeat (W + 4) tick();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) req = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a0 = W'($urandom); b0 = W'($urandom); op0 = 3'($urandom_range(0, 7));
        a1 = W'($urandom); b1 = W'($urandom); op1 = 3'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    req = 2'b00;
    repeat (W + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_arbiter.md
SERIAL_ALU_ARBITER -- requirements
Module: serial_alu_arbiter

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have the port req, input, 2 bits, one operation request per requester (index 0, 1).
REQ-005 The block SHALL have the ports a0, b0, a1, b1, each input, WIDTH bits, the operands of requester 0 and requester 1.
REQ-006 The block SHALL have the ports op0 and op1, each input, 3 bits, with encoding 000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR; 101-111 are treated as ADD.
REQ-007 The block SHALL have the port gnt, output, 2 bits, one-hot, high from the LOAD cycle through the DONE cycle of the granted requester.
REQ-008 The block SHALL have the port busy, output, 1 bit, high in every state except IDLE.
REQ-009 The block SHALL have the port done, output, 2 bits, a one-cycle pulse to the owning requester in the DONE state.
REQ-010 The block SHALL have the port result, output, WIDTH bits, the completed result; it is valid in DONE and held until the next LOAD.
REQ-011 The block SHALL have the port carry_out, output, 1 bit, the final carry for ADD/SUB and 0 for logic ops; it is held like result.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, EXEC and DONE.
- IDLE->LOAD when any req bit is high.
- LOAD->EXEC after 1 cycle.
- EXEC->DONE when the bit counter reaches WIDTH-1.
- DONE->IDLE after 1 cycle.
REQ-013 Arbitration SHALL be round-robin.
- A last-grant pointer selects the winner: with both requests high, the requester not granted last wins.
- With one request high, that requester wins.
- The pointer updates in LOAD.
REQ-014 In LOAD the block SHALL latch the winner's a, b and op into internal shift registers, clear the bit counter, and set the carry flop to 1 for SUB and to 0 otherwise.
REQ-015 For SUB, the B operand SHALL be bitwise inverted at latch time, so that SUB computes a + ~b + 1.
REQ-016 In each EXEC cycle the block SHALL:
- process one bit, LSB first;
- shift A and B right by one;
- shift the result bit into the MSB of the result shift register;
- update the carry flop (ADD/SUB only);
- increment the counter.
REQ-017 EXEC SHALL last exactly WIDTH cycles.
- Latency from the IDLE cycle that samples req to the done pulse is WIDTH+2 cycles.
- The block accepts a new request in the cycle after DONE.
REQ-018 Inputs a, b and op SHALL be sampled only in LOAD; changes afterwards have no effect on the operation in progress.
REQ-019 Deasserting req after LOAD SHALL NOT abort the operation: it completes and done still pulses.
REQ-020 A req of the non-granted requester arriving during LOAD/EXEC/DONE SHALL be held off; gnt stays on the owner.
REQ-021 result and carry_out SHALL update only on the EXEC->DONE transition, so they are never visible half-shifted.
REQ-022 ADD/SUB results SHALL wrap modulo 2^WIDTH, with the carry out of the MSB reported on carry_out (SUB: 1 means no borrow).

Reset
REQ-023 When rst is high at a clock edge, the block SHALL set:
- state = IDLE;
- gnt = 00, busy = 0, done = 00;
- result = 0, carry_out = 0;
- counter = 0;
- last-grant pointer = 1, so requester 0 wins the first tie.
REQ-024 A reset asserted mid-EXEC SHALL abandon the operation with no done pulse; the first request after rst deasserts is accepted as from IDLE.

Configuration
REQ-025 The block SHALL support the macro SERIAL_ALU_FLAGS_EN.
- When defined, it adds the outputs zero (1 bit: result == 0) and ovf (1 bit: signed overflow of ADD/SUB, 0 for logic ops).
- Both flags update together with result, are held until the next LOAD, and reset to 0.
- When undefined, these ports and their logic are absent and all other behaviour is identical.

Verification (WIDTH=8)
REQ-026 req=01, a0=0x5A, b0=0x3C, op0=ADD -> gnt=01 from the cycle after request; done=01 exactly 10 cycles after request sampling; result=0x96, carry_out=0 (flags: zero=0, ovf=1).
REQ-027 req=10, a1=0x10, b1=0x01, op1=SUB -> result=0x0F, carry_out=1; a1=0x00, b1=0x01, SUB -> result=0xFF, carry_out=0.
REQ-028 req=11 held continuously after reset, both XOR with operands 0xF0/0x0F -> grants alternate 01,10,01,10; each result is 0xFF; exactly one done pulse per operation.
REQ-029 Start ADD 0xFF+0x01 on requester 0 and change a0/op0 during EXEC -> result=0x00, carry_out=1 (flags: zero=1), unaffected by the changes.
REQ-030 Assert rst in the 4th EXEC cycle -> the next cycle shows busy=0, gnt=00, result=0; no done pulse; a subsequent req=11 is granted to requester 0.
REQ-031 Requester 0 drops req after LOAD, op0=AND with a0=0xCC, b0=0xAA -> done=01 still pulses; result=0x88, carry_out=0; op0=111 behaves as ADD.
